// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, GF(2^8) helpers and round-stage FSM states
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int         STATE_W  = 128;

    typedef enum logic {
        IDLE = 1'b0,
        COL  = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Column-major state: byte 4c+r holds s[r][c]; row r rotates left by r columns.
    function automatic logic [0:STATE_W-1] shift_rows(input logic [0:STATE_W-1] s);
        logic [0:STATE_W-1] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_mix_columns_if.sv
// rtl/shift_mix_columns_if.sv - state handshake between SubBytes, this stage and AddRoundKey
interface shift_mix_columns_if;
    import aes_pkg::*;

    logic [0:STATE_W-1] in_data;
    logic               in_ready;
    logic               last_round;
    logic [0:STATE_W-1] out_data;
    logic               out_ready;
    logic               busy;

    modport master (
        output in_data, in_ready, last_round,
        input  out_data, out_ready, busy
    );

    modport slave (
        input  in_data, in_ready, last_round,
        output out_data, out_ready, busy
    );

endinterface

// File: rtl/gf_mix_column.sv
// rtl/gf_mix_column.sv - combinational MixColumns on one 32-bit column
module gf_mix_column
    import aes_pkg::*;
(
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[0:7];
    assign a1 = col_in[8:15];
    assign a2 = col_in[16:23];
    assign a3 = col_in[24:31];

    assign col_out[0:7]   = xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    assign col_out[8:15]  = a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3;
    assign col_out[16:23] = a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3);
    assign col_out[24:31] = gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/shift_mix_columns.sv
// rtl/shift_mix_columns.sv - ShiftRows at capture, then MixColumns one column per cycle
module shift_mix_columns
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    shift_mix_columns_if.slave bus
);

    state_t             state;
    logic [1:0]         cnt;
    logic [0:STATE_W-1] st_q;
    logic               last_q;
    logic [0:STATE_W-1] out_q;
    logic               out_ready_q;
    logic               busy_q;

    logic [0:31] col_in;
    logic [0:31] col_mix;
    logic [0:31] col_res;

    assign col_in  = st_q[{cnt, 5'b0} +: 32];
    assign col_res = last_q ? col_in : col_mix;

    gf_mix_column u_col (
        .col_in  (col_in),
        .col_out (col_mix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            st_q        <= '0;
            last_q      <= 1'b0;
            out_q       <= '0;
            out_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_ready) begin
                        st_q   <= shift_rows(bus.in_data);
                        last_q <= bus.last_round;
                        cnt    <= 2'd0;
                        busy_q <= 1'b1;
                        state  <= COL;
                    end
                end
                COL: begin
                    out_q[{cnt, 5'b0} +: 32] <= col_res;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        out_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_ready = out_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// tb/tb_shift_mix_columns.sv - randomized self-checking bench for shift_mix_columns
module tb_shift_mix_columns;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic prev_or = 1'b0;

    shift_mix_columns_if bus ();

    shift_mix_columns dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:127] ref_model(input logic [0:127] d, input logic lr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] o [4][4];
        logic [7:0] m [4][4];
        logic [0:127] res;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[8*(4*c+r) +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o[r][c] = 8'h00;
                for (int k = 0; k < 4; k++) o[r][c] = o[r][c] ^ gmul(m[r][k], t[k][c]);
                res[8*(4*c+r) +: 8] = lr ? t[r][c] : o[r][c];
            end
        return res;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_ready) check("out_ready_consecutive", prev_or, 1'b0);
        prev_or = bus.out_ready;
    end

    // Starts a block in the current cycle n and returns #1 into cycle n+5.
    task automatic run_block(input logic [0:127] d, input logic lr, input logic [0:127] exp,
                             input string tag, input bit noise);
        bus.in_data    = d;
        bus.last_round = lr;
        bus.in_ready   = 1'b1;
        @(posedge clk); #1;
        bus.in_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_busy"}, bus.busy, 1'b1);
            check({tag, "_early_out_ready"}, bus.out_ready, 1'b0);
            if (noise) begin
                bus.in_ready   = 1'($urandom_range(0, 1));
                bus.in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.last_round = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        bus.in_ready = 1'b0;
        check({tag, "_out_ready"}, bus.out_ready, 1'b1);
        check({tag, "_busy_done"}, bus.busy, 1'b0);
        check({tag, "_out_data"}, bus.out_data, exp);
    endtask

    localparam logic [0:127] FIPS_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [0:127] FIPS_MIX  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [0:127] FIPS_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] INV_IN    = 128'hdb135345db135345db135345db135345;
    localparam logic [0:127] INV_OUT   = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;

    initial begin
        logic [0:127] d;
        logic         lr;
        reset          = 1'b1;
        bus.in_data    = '0;
        bus.in_ready   = 1'b0;
        bus.last_round = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_out_ready", bus.out_ready, 1'b0);
        check("reset_out_data", bus.out_data, 128'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_block(FIPS_IN, 1'b0, FIPS_MIX, "fips_round1", 1'b0);
        run_block(FIPS_IN, 1'b1, FIPS_SR, "fips_last_b2b", 1'b0);
        run_block(INV_IN, 1'b0, INV_OUT, "shift_invariant", 1'b1);
        @(posedge clk); #1;

        bus.in_data    = FIPS_IN;
        bus.last_round = 1'b0;
        bus.in_ready   = 1'b1;
        @(posedge clk); #1;
        bus.in_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_out_ready", bus.out_ready, 1'b0);
        check("midreset_out_data", bus.out_data, 128'h0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("midreset_no_output", bus.out_ready, 1'b0);
        end
        run_block(FIPS_IN, 1'b0, FIPS_MIX, "after_reset", 1'b0);

        for (int i = 0; i < 1000; i++) begin
            d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            lr = 1'($urandom_range(0, 1));
            run_block(d, lr, ref_model(d, lr), "random", 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
